cpu_4bit: RTL and testbench

Top-level 4-bit accumulator CPU with a 16 x 4-bit unified program/data nibble memory, a multi-cycle control unit, a ripple-carry ALU, 4-bit input/output pin ports and a UART (8N1) loader. While the program pin is high the core is halted and received bytes are written into memory as nibble pairs. When the pin is released, execution restarts from address 0.

---
 rtl/cpu_4bit.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_cpu_4bit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_4bit.sv
// 4-bit accumulator CPU with a 16-nibble unified program/data memory and a UART (8N1) loader.
// While p_programm_i is high the core is parked at address 0 and the loader owns the write port.
module cpu_4bit #(
   parameter int CRA_BIT_NUMB               = 4,
   parameter int OPERATION_CODE_WIDTH       = 3,
   parameter int REGISTER_WIDTH             = 4,
   parameter int MEMORY_ADDRESS_WIDTH       = 4,
   parameter int MEMORY_REGISTERS           = 16,
   parameter int UART_DATA_LENGTH           = 8,
   parameter int RX_COUNTER_BITWIDTH        = 3,
   parameter int BAUD_COUNTS_PER_BIT        = 521,
   parameter int BAUD_RATE_COUNTER_BITWIDTH = 10
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [REGISTER_WIDTH-1:0] in_pins_i,
   output logic [REGISTER_WIDTH-1:0] out_pins_o,
   input  logic                      p_programm_i,
   input  logic                      rx_i
);
   localparam int W   = REGISTER_WIDTH;
   localparam int AW  = MEMORY_ADDRESS_WIDTH;
   localparam int BW  = BAUD_RATE_COUNTER_BITWIDTH;
   localparam int RCW = RX_COUNTER_BITWIDTH;
   localparam int OW  = OPERATION_CODE_WIDTH;

   localparam logic [3:0] OP_NOP = 4'h0, OP_XOR = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4, OP_INC = 4'h5, OP_DEC = 4'h6, OP_SUB = 4'h7;
   localparam logic [3:0] OP_JMP = 4'h8, OP_JZ  = 4'h9, OP_JC  = 4'hA, OP_LD  = 4'hB;
   localparam logic [3:0] OP_ST  = 4'hC, OP_IN  = 4'hD, OP_OUT = 4'hE, OP_LDI = 4'hF;

   localparam logic [1:0] S_FETCH = 2'd0, S_OPERAND = 2'd1, S_EXECUTE = 2'd2;
   localparam logic [1:0] LD_IDLE = 2'd0, LD_START = 2'd1, LD_DATA = 2'd2, LD_STOP = 2'd3;

   localparam logic [OW-1:0] ALU_ADD = 3'd0, ALU_XOR = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3;

   localparam logic [BW-1:0]  BIT_LAST  = BW'(BAUD_COUNTS_PER_BIT - 1);
   localparam logic [BW-1:0]  HALF_LAST = BW'(BAUD_COUNTS_PER_BIT / 2 - 1);
   localparam logic [RCW-1:0] LAST_BIT  = RCW'(UART_DATA_LENGTH - 1);

   function automatic logic has_operand(input logic [W-1:0] op);
      return !(op inside {OP_NOP, OP_INC, OP_DEC, OP_IN, OP_OUT});
   endfunction

   // core state
   logic [1:0]    state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [W-1:0]  ir_q, ir_d, opr_q, opr_d, a_q, a_d, out_q, out_d;
   logic          c_q, c_d, z_q, z_d, prog_q;
   logic [W-1:0]  mem_q [MEMORY_REGISTERS];
   logic [W-1:0]  mem_d [MEMORY_REGISTERS];
   logic          core_we;

   // loader state
   logic                        rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
   logic [1:0]                  ld_state_q, ld_state_d;
   logic [BW-1:0]               baud_cnt_q, baud_cnt_d;
   logic [RCW-1:0]              bit_cnt_q, bit_cnt_d;
   logic [UART_DATA_LENGTH-1:0] shift_q, shift_d;
   logic [AW-1:0]               waddr_q, waddr_d, ld_addr;
   logic                        lo_pend_q, lo_pend_d, ld_we;
   logic [W-1:0]                ld_data;

   // ALU
   logic [OW-1:0] alu_op;
   logic [W-1:0]  alu_b, alu_res, add_sum, mem_opr;
   logic          alu_cin, alu_c, add_cout;

   assign mem_opr    = mem_q[opr_q];
   assign out_pins_o = out_q;

   // SUB and DEC reuse the adder: A + ~M + 1 and A + F.
   always_comb begin
      alu_op  = ALU_ADD;
      alu_b   = mem_opr;
      alu_cin = 1'b0;
      case (ir_q)
         OP_XOR:  alu_op = ALU_XOR;
         OP_AND:  alu_op = ALU_AND;
         OP_OR:   alu_op = ALU_OR;
         OP_SUB:  begin alu_b = ~mem_opr; alu_cin = 1'b1; end
         OP_INC:  begin alu_b = '0;       alu_cin = 1'b1; end
         OP_DEC:  alu_b = '1;
         default: ;
      endcase
   end

   always_comb begin : cra
      logic carry;
      add_sum = '0;
      carry   = alu_cin;
      for (int i = 0; i < CRA_BIT_NUMB; i++) begin
         add_sum[i] = a_q[i] ^ alu_b[i] ^ carry;
         carry      = (a_q[i] & alu_b[i]) | (carry & (a_q[i] ^ alu_b[i]));
      end
      add_cout = carry;
   end

   always_comb begin
      alu_res = add_sum;
      alu_c   = add_cout;
      case (alu_op)
         ALU_XOR: begin alu_res = a_q ^ alu_b; alu_c = 1'b0; end
         ALU_AND: begin alu_res = a_q & alu_b; alu_c = 1'b0; end
         ALU_OR:  begin alu_res = a_q | alu_b; alu_c = 1'b0; end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      opr_d   = opr_q;
      a_d     = a_q;
      c_d     = c_q;
      z_d     = z_q;
      out_d   = out_q;
      core_we = 1'b0;
      if (p_programm_i) begin
         state_d = S_FETCH;
         pc_d    = '0;
      end else if (prog_q) begin
         // first cycle after programming: restart cleanly from address 0
         state_d = S_FETCH;
         pc_d    = '0;
         a_d     = '0;
         c_d     = 1'b0;
         z_d     = 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               ir_d    = mem_q[pc_q];
               pc_d    = pc_q + AW'(1);
               state_d = has_operand(mem_q[pc_q]) ? S_OPERAND : S_EXECUTE;
            end
            S_OPERAND: begin
               opr_d   = mem_q[pc_q];
               pc_d    = pc_q + AW'(1);
               state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
               state_d = S_FETCH;
               case (ir_q)
                  OP_XOR, OP_AND, OP_OR, OP_ADD, OP_INC, OP_DEC, OP_SUB: begin
                     a_d = alu_res;
                     c_d = alu_c;
                     z_d = (alu_res == '0);
                  end
                  OP_JMP:  pc_d = opr_q;
                  OP_JZ:   if (z_q) pc_d = opr_q;
                  OP_JC:   if (c_q) pc_d = opr_q;
                  OP_LD:   a_d = mem_opr;
                  OP_ST:   core_we = 1'b1;
                  OP_IN:   a_d = in_pins_i;
                  OP_OUT:  out_d = a_q;
                  OP_LDI:  a_d = opr_q;
                  default: ;
               endcase
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_comb begin
      rx_meta_d  = rx_i;
      rx_sync_d  = rx_meta_q;
      rx_prev_d  = rx_sync_q;
      ld_state_d = ld_state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      waddr_d    = waddr_q;
      lo_pend_d  = 1'b0;
      ld_we      = 1'b0;
      ld_addr    = waddr_q;
      ld_data    = shift_q[UART_DATA_LENGTH-1 -: W];
      if (!p_programm_i) begin
         ld_state_d = LD_IDLE;
      end else begin
         if (lo_pend_q) begin
            ld_we   = 1'b1;
            ld_addr = waddr_q + AW'(1);
            ld_data = shift_q[W-1:0];
            waddr_d = waddr_q + AW'(2);
         end
         if (!prog_q) waddr_d = '0;
         case (ld_state_q)
            LD_IDLE: begin
               if (rx_prev_q && !rx_sync_q) begin
                  ld_state_d = LD_START;
                  baud_cnt_d = '0;
               end
            end
            LD_START: begin
               if (baud_cnt_q == HALF_LAST) begin
                  baud_cnt_d = '0;
                  bit_cnt_d  = '0;
                  ld_state_d = rx_sync_q ? LD_IDLE : LD_DATA;
               end else begin
                  baud_cnt_d = baud_cnt_q + BW'(1);
               end
            end
            LD_DATA: begin
               if (baud_cnt_q == BIT_LAST) begin
                  baud_cnt_d = '0;
                  shift_d    = {rx_sync_q, shift_q[UART_DATA_LENGTH-1:1]};
                  bit_cnt_d  = bit_cnt_q + RCW'(1);
                  if (bit_cnt_q == LAST_BIT) ld_state_d = LD_STOP;
               end else begin
                  baud_cnt_d = baud_cnt_q + BW'(1);
               end
            end
            default: begin
               if (baud_cnt_q == BIT_LAST) begin
                  ld_state_d = LD_IDLE;
                  if (rx_sync_q) begin
                     ld_we     = 1'b1;
                     lo_pend_d = 1'b1;
                  end
               end else begin
                  baud_cnt_d = baud_cnt_q + BW'(1);
               end
            end
         endcase
      end
   end

   // single write port, owned by the loader in programming mode and by ST otherwise
   always_comb begin
      mem_d = mem_q;
      if (p_programm_i) begin
         if (ld_we) mem_d[ld_addr] = ld_data;
      end else if (core_we) begin
         mem_d[opr_q] = a_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_FETCH;
         pc_q       <= '0;
         ir_q       <= '0;
         opr_q      <= '0;
         a_q        <= '0;
         c_q        <= 1'b0;
         z_q        <= 1'b0;
         out_q      <= '0;
         prog_q     <= 1'b0;
         mem_q      <= '{default: '0};
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         ld_state_q <= LD_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         waddr_q    <= '0;
         lo_pend_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         opr_q      <= opr_d;
         a_q        <= a_d;
         c_q        <= c_d;
         z_q        <= z_d;
         out_q      <= out_d;
         prog_q     <= p_programm_i;
         mem_q      <= mem_d;
         rx_meta_q  <= rx_meta_d;
         rx_sync_q  <= rx_sync_d;
         rx_prev_q  <= rx_prev_d;
         ld_state_q <= ld_state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         waddr_q    <= waddr_d;
         lo_pend_q  <= lo_pend_d;
      end
   end

endmodule

// File: tb/tb_cpu_4bit.sv
// Bench for cpu_4bit: UART program loads at 521 clocks/bit and an instruction-level ISA model
// that is stepped alongside the core and compared at every instruction boundary.
module tb_cpu_4bit;
   localparam int BAUD = 521;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic [3:0] in_pins  = 4'h0;
   logic [3:0] out_pins;
   logic       prog     = 1'b0;
   logic       rx       = 1'b1;

   int checks   = 0;
   int failures = 0;

   int m_mem[16];
   int m_pc, m_a, m_c, m_z, m_out, m_waddr;
   int outs_q[$];

   logic [7:0] prog_main [7] = '{8'hDE, 8'hCF, 8'h4F, 8'hAA, 8'h81, 8'h58, 8'h10};
   logic [7:0] prog_flag [5] = '{8'hF3, 8'h71, 8'h97, 8'h56, 8'hA0};
   int         exp_main  [16] = '{13, 14, 12, 15, 4, 15, 10, 10, 8, 1, 5, 8, 1, 0, 0, 0};
   int         exp_outs  [8]  = '{2, 4, 8, 1, 2, 4, 8, 1};

   cpu_4bit dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .in_pins_i    (in_pins),
      .out_pins_o   (out_pins),
      .p_programm_i (prog),
      .rx_i         (rx)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 0;
      m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_out = 0; m_waddr = 0;
   endtask

   task automatic model_load(input logic [7:0] b);
      m_mem[m_waddr]            = int'(b[7:4]);
      m_mem[(m_waddr + 1) % 16] = int'(b[3:0]);
      m_waddr                   = (m_waddr + 2) % 16;
   endtask

   // Executes one whole instruction from the ISA definition; returns its cycle count.
   task automatic model_step(output int cyc);
      int op, opr, m, s;
      op   = m_mem[m_pc];
      m_pc = (m_pc + 1) % 16;
      cyc  = 2;
      opr  = 0;
      if (!(op inside {0, 5, 6, 13, 14})) begin
         opr  = m_mem[m_pc];
         m_pc = (m_pc + 1) % 16;
         cyc  = 3;
      end
      m = m_mem[opr];
      s = -1;
      case (op)
         1:  begin m_a = m_a ^ m; m_c = 0; m_z = (m_a == 0) ? 1 : 0; end
         2:  begin m_a = m_a & m; m_c = 0; m_z = (m_a == 0) ? 1 : 0; end
         3:  begin m_a = m_a | m; m_c = 0; m_z = (m_a == 0) ? 1 : 0; end
         4:  s = m_a + m;
         5:  s = m_a + 1;
         6:  s = m_a + 15;
         7:  s = m_a + (15 - m) + 1;
         8:  m_pc = opr;
         9:  if (m_z != 0) m_pc = opr;
         10: if (m_c != 0) m_pc = opr;
         11: m_a = m;
         12: m_mem[opr] = m_a;
         13: m_a = int'(in_pins);
         14: m_out = m_a;
         15: m_a = opr;
         default: ;
      endcase
      if (s >= 0) begin
         m_c = (s > 15) ? 1 : 0;
         m_a = s % 16;
         m_z = (m_a == 0) ? 1 : 0;
      end
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_a"},   int'(dut.a_q),  m_a);
      check_eq({tag, "_c"},   int'(dut.c_q),  m_c);
      check_eq({tag, "_z"},   int'(dut.z_q),  m_z);
      check_eq({tag, "_pc"},  int'(dut.pc_q), m_pc);
      check_eq({tag, "_out"}, int'(out_pins), m_out);
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 16; i++)
         check_eq($sformatf("%s_mem%0d", tag, i), int'(dut.mem_q[i]), m_mem[i]);
   endtask

   task automatic run_instrs(input int n, input bit rand_in, input string tag);
      for (int k = 0; k < n; k++) begin
         int cyc;
         int prev;
         if (rand_in) in_pins = 4'($urandom_range(0, 15));
         prev = int'(out_pins);
         model_step(cyc);
         repeat (cyc) tick();
         check_state($sformatf("%s%0d", tag, k));
         if (int'(out_pins) != prev) outs_q.push_back(int'(out_pins));
      end
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (BAUD) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BAUD) tick();
      end
      rx = stop_bit;
      repeat (BAUD) tick();
      rx = 1'b1;
      repeat (stop_bit ? 20 : BAUD) tick();
   endtask

   task automatic enter_prog(input string tag);
      prog = 1'b1;
      tick();
      m_waddr = 0;
      check_eq({tag, "_pc"}, int'(dut.pc_q), 0);
      check_eq({tag, "_waddr"}, int'(dut.waddr_q), 0);
   endtask

   task automatic release_prog(input string tag);
      prog = 1'b0;
      tick();
      m_pc = 0; m_a = 0; m_c = 0; m_z = 0;
      check_state(tag);
   endtask

   initial begin
      model_reset();
      repeat (3) tick();
      check_state("rst");
      check_mem("rst");
      reset = 1'b0;

      // NOP-filled memory: 50 two-cycle instructions = 100 idle cycles
      run_instrs(50, 1'b1, "idle");
      check_mem("idle");

      enter_prog("p1");
      foreach (prog_main[i]) begin
         uart_send(prog_main[i], 1'b1);
         model_load(prog_main[i]);
      end
      for (int i = 0; i < 16; i++)
         check_eq($sformatf("load_mem%0d", i), int'(dut.mem_q[i]), exp_main[i]);
      check_eq("p1_hold_a", int'(dut.a_q), m_a);
      check_eq("p1_hold_out", int'(out_pins), m_out);

      in_pins = 4'h2;
      release_prog("rel1");
      outs_q.delete();
      run_instrs(45, 1'b0, "main");
      check_eq("out_count_ok", (outs_q.size() >= 8) ? 1 : 0, 1);
      for (int i = 0; i < 8 && i < outs_q.size(); i++)
         check_eq($sformatf("out_seq%0d", i), outs_q[i], exp_outs[i]);
      check_mem("main");

      enter_prog("p2");
      check_eq("p2_hold_a", int'(dut.a_q), m_a);
      check_eq("p2_hold_c", int'(dut.c_q), m_c);
      check_eq("p2_hold_out", int'(out_pins), m_out);
      uart_send(8'($urandom_range(0, 255)), 1'b0);
      check_eq("frm_waddr", int'(dut.waddr_q), m_waddr);
      check_mem("frm");
      foreach (prog_flag[i]) begin
         uart_send(prog_flag[i], 1'b1);
         model_load(prog_flag[i]);
         if (i == 0) check_eq("frm_next_waddr", int'(dut.waddr_q), 2);
      end
      check_mem("p2");

      release_prog("rel2");
      run_instrs(2, 1'b0, "fl");
      check_eq("sub_a", int'(dut.a_q), 0);
      check_eq("sub_z", int'(dut.z_q), 1);
      check_eq("sub_c", int'(dut.c_q), 1);
      run_instrs(1, 1'b0, "jz");
      check_eq("jz_pc", int'(dut.pc_q), 7);
      run_instrs(1, 1'b0, "dec");
      check_eq("dec_a", int'(dut.a_q), 15);
      check_eq("dec_c", int'(dut.c_q), 0);
      check_eq("dec_z", int'(dut.z_q), 0);
      run_instrs(1, 1'b0, "jc");
      check_eq("jc_pc", int'(dut.pc_q), 10);
      run_instrs(20, 1'b1, "fr");

      // reset in the middle of an instruction
      tick();
      reset = 1'b1;
      tick();
      model_reset();
      check_state("rmid");
      check_mem("rmid");
      reset = 1'b0;

      // reset in the middle of a frame: start bit plus three zero data bits, then abort
      prog = 1'b1;
      tick();
      rx = 1'b0;
      repeat (4 * BAUD) tick();
      reset = 1'b1;
      rx    = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      check_eq("rfrm_waddr", int'(dut.waddr_q), 0);
      check_eq("rfrm_out", int'(out_pins), 0);
      repeat (20) tick();
      begin
         logic [7:0] b;
         b = 8'($urandom_range(0, 255));
         uart_send(b, 1'b1);
         model_load(b);
      end
      check_mem("rfrm");
      check_eq("rfrm_waddr2", int'(dut.waddr_q), m_waddr);
      release_prog("rel3");
      run_instrs(12, 1'b1, "post");
      check_mem("post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
